// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq: binary request side and BCD result side.
// The master modport is the producer/consumer environment; the slave modport is the converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, overflow
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional macro BCD_LEADING_ZERO_BLANK_EN replaces leading zero digits (except digit 0) with 4'hF.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     bcd_q, bcd_d;

  logic [SW-1:0]     adj;
  logic [SW-1:0]     shift_scr;
  logic              shift_ovf;
  logic [SW-1:0]     final_bcd;
  logic              in_ready_c;

  // Add-3 correction on every digit that would reach 10 or more after doubling.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
  assign shift_scr = {adj[SW-2:0], bin_q[BIN_W-1]};
  assign shift_ovf = ovf_q | adj[SW-1];

  // Presentation value, computed from the result of the final shift so it can be registered.
  always_comb begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead;
    lead      = 1'b1;
`endif
    final_bcd = shift_scr;
    if (shift_ovf) begin
      final_bcd = {DIGITS{4'h9}};
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    else begin
      // NOTE: 'lead' is a blocking temporary that carries state between loop iterations
      // within this evaluation only; it is always assigned before use, so no latch results.
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && (shift_scr[4*k +: 4] == 4'd0)) begin
          final_bcd[4*k +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  assign in_ready_c = (state_q == IDLE) && !rst;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          bin_d     = bus.bin_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shift_scr;
        bin_d     = bin_q << 1;
        ovf_d     = shift_ovf;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = final_bcd;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
  // the result register is cleared by rst so bcd_out reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance driven in lockstep.
// Expected codes follow BCD_LEADING_ZERO_BLANK_EN when it is defined.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] bin_in;
  int         n_checks = 0;
  int         n_fail   = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [11:0] EXP_0  = 12'hFF0;
  localparam logic [11:0] EXP_9  = 12'hFF9;
  localparam logic [11:0] EXP_42 = 12'hF42;
  localparam logic [11:0] EXP_99 = 12'hF99;
`else
  localparam logic [11:0] EXP_0  = 12'h000;
  localparam logic [11:0] EXP_9  = 12'h009;
  localparam logic [11:0] EXP_42 = 12'h042;
  localparam logic [11:0] EXP_99 = 12'h099;
`endif

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) a_if ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b_if ();

  assign a_if.in_valid  = in_valid;
  assign a_if.bin_in    = bin_in;
  assign a_if.out_ready = out_ready;
  assign b_if.in_valid  = in_valid;
  assign b_if.bin_in    = bin_in;
  assign b_if.out_ready = out_ready;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // Presents v for one accepting edge; returns at the falling edge right after it.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts falling edges until out_valid; gives up at 40.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!a_if.out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_if.in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready_low: got %b want 0", a_if.in_ready); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.bcd_out !== 12'h000 || a_if.overflow !== 1'b0) begin
      $display("FAIL reset_outputs: got v=%b bcd=%h ovf=%b want 0/000/0",
               a_if.out_valid, a_if.bcd_out, a_if.overflow); n_fail++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_if.in_ready !== 1'b1) begin
      $display("FAIL reset_release_in_ready: got %b want 1", a_if.in_ready); n_fail++;
    end
  endtask

  task automatic test_zero();
    int c;
    accept(8'd0);
    wait_valid(c);
    n_checks++;
    if (c !== 8) begin
      $display("FAIL zero_latency: got %0d want 8", c); n_fail++;
    end
    n_checks++;
    if (a_if.bcd_out !== EXP_0 || a_if.overflow !== 1'b0) begin
      $display("FAIL zero_value: got %h ovf=%b want %h ovf=0", a_if.bcd_out, a_if.overflow, EXP_0); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0) begin
      $display("FAIL zero_single_pulse: got out_valid=%b want 0", a_if.out_valid); n_fail++;
    end
  endtask

  task automatic test_max();
    int c;
    accept(8'd255);
    wait_valid(c);
    n_checks++;
    if (c !== 8 || a_if.bcd_out !== 12'h255 || a_if.overflow !== 1'b0) begin
      $display("FAIL max_value: got lat=%0d %h ovf=%b want 8 255 0", c, a_if.bcd_out, a_if.overflow); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0) begin
      $display("FAIL max_return_idle: got in_ready=%b out_valid=%b want 1 0", a_if.in_ready, a_if.out_valid); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 8'd9;
    @(negedge clk);
    n_checks++;
    if (a_if.in_ready !== 1'b0) begin
      $display("FAIL b2b_busy: got in_ready=%b want 0", a_if.in_ready); n_fail++;
    end
    bin_in = 8'd170;
    wait_valid(c);
    n_checks++;
    if (c !== 8 || a_if.bcd_out !== EXP_9) begin
      $display("FAIL b2b_first: got lat=%0d %h want 8 %h", c, a_if.bcd_out, EXP_9); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (a_if.in_ready !== 1'b1) begin
      $display("FAIL b2b_idle_gap: got in_ready=%b want 1", a_if.in_ready); n_fail++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (a_if.in_ready !== 1'b0) begin
      $display("FAIL b2b_second_accept: got in_ready=%b want 0", a_if.in_ready); n_fail++;
    end
    wait_valid(c);
    n_checks++;
    if (c !== 8 || a_if.bcd_out !== 12'h170) begin
      $display("FAIL b2b_second: got lat=%0d %h want 8 170", c, a_if.bcd_out); n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int c;
    out_ready = 1'b0;
    accept(8'd123);
    wait_valid(c);
    n_checks++;
    if (c !== 8 || a_if.bcd_out !== 12'h123) begin
      $display("FAIL bp_value: got lat=%0d %h want 8 123", c, a_if.bcd_out); n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      bin_in   = 8'(i * 41 + 7);
      @(negedge clk);
      n_checks++;
      if (a_if.out_valid !== 1'b1 || a_if.bcd_out !== 12'h123 || a_if.in_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d: got v=%b %h rdy=%b want 1 123 0",
                 i, a_if.out_valid, a_if.bcd_out, a_if.in_ready); n_fail++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1) begin
      $display("FAIL bp_release: got v=%b rdy=%b want 0 1", a_if.out_valid, a_if.in_ready); n_fail++;
    end
  endtask

  task automatic test_overflow();
    int c;
    accept(8'd200);
    wait_valid(c);
    n_checks++;
    if (b_if.out_valid !== 1'b1 || b_if.overflow !== 1'b1 || b_if.bcd_out !== 8'h99) begin
      $display("FAIL ovf_200: got v=%b ovf=%b %h want 1 1 99", b_if.out_valid, b_if.overflow, b_if.bcd_out); n_fail++;
    end
    n_checks++;
    if (a_if.overflow !== 1'b0 || a_if.bcd_out !== 12'h200) begin
      $display("FAIL wide_200: got ovf=%b %h want 0 200", a_if.overflow, a_if.bcd_out); n_fail++;
    end
    @(negedge clk);
    accept(8'd99);
    wait_valid(c);
    n_checks++;
    if (b_if.out_valid !== 1'b1 || b_if.overflow !== 1'b0 || b_if.bcd_out !== 8'h99) begin
      $display("FAIL ovf_99: got v=%b ovf=%b %h want 1 0 99", b_if.out_valid, b_if.overflow, b_if.bcd_out); n_fail++;
    end
    n_checks++;
    if (a_if.bcd_out !== EXP_99) begin
      $display("FAIL wide_99: got %h want %h", a_if.bcd_out, EXP_99); n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    int seen;
    accept(8'd77);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0 || a_if.bcd_out !== 12'h000) begin
      $display("FAIL rst_mid_state: got rdy=%b v=%b %h want 1 0 000",
               a_if.in_ready, a_if.out_valid, a_if.bcd_out); n_fail++;
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_if.out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      $display("FAIL rst_mid_no_valid: got %0d valid cycles want 0", seen); n_fail++;
    end
    accept(8'd42);
    wait_valid(c);
    n_checks++;
    if (c !== 8 || a_if.bcd_out !== EXP_42) begin
      $display("FAIL rst_mid_next: got lat=%0d %h want 8 %h", c, a_if.bcd_out, EXP_42); n_fail++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    bin_in    = 8'd0;
    out_ready = 1'b1;
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
